// File: rtl/cartpole_pkg.sv
// -----------------------------------------------------------------------------
// cartpole_pkg
// Shared definitions for the CartPole episode controller:
//   - float32 word width and state-vector layout (4 words, x in the low word)
//   - word offsets inside the packed state vector
//   - episode FSM state encoding
//   - frequently used float32 constants
// -----------------------------------------------------------------------------
package cartpole_pkg;

    localparam int DATA_BIT    = 32;
    localparam int STATE_WORDS = 4;
    localparam int STATE_BIT   = STATE_WORDS * DATA_BIT;

    // Word offsets inside {theta_dot, theta, x_dot, x}
    localparam int IDX_X         = 0;
    localparam int IDX_X_DOT     = 1;
    localparam int IDX_THETA     = 2;
    localparam int IDX_THETA_DOT = 3;

    localparam logic [DATA_BIT-1:0] FP_ONE  = 32'h3F80_0000;
    localparam logic [DATA_BIT-1:0] FP_ZERO = 32'h0000_0000;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_READY,
        ST_ISSUE,
        ST_WAIT,
        ST_PRESENT,
        ST_DONE,
        ST_ERR
    } ctrl_state_e;

    // Extract one float32 word from a packed state vector
    function automatic logic [DATA_BIT-1:0] state_word(input logic [STATE_BIT-1:0] vec,
                                                       input int                   idx);
        return vec[idx*DATA_BIT +: DATA_BIT];
    endfunction

endpackage

// File: rtl/cartpole_step_timer.sv
// -----------------------------------------------------------------------------
// cartpole_step_timer
// Timeout counter for one datapath step. Counts while enabled and saturates at
// TIMEOUT_CYC-1; o_expire is high while enabled and the last count is reached.
//   aclk, aresetn : clock, asynchronous active-low reset
//   i_clr         : synchronous clear to zero (wins over i_en)
//   i_en          : count enable
//   o_expire      : timeout reached this cycle
// -----------------------------------------------------------------------------
module cartpole_step_timer #(
    parameter int TIMEOUT_CYC = 64
) (
    input  logic aclk,
    input  logic aresetn,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expire
);

    localparam int CNT_BIT = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_BIT-1:0] LAST_CNT = CNT_BIT'(TIMEOUT_CYC - 1);

    logic [CNT_BIT-1:0] cnt_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values of its neighbours.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cnt_q <= '0;
        end else if (i_clr) begin
            cnt_q <= '0;
        end else if (i_en && (cnt_q != LAST_CNT)) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign o_expire = i_en && (cnt_q == LAST_CNT);

endmodule

// File: rtl/cartpole_episode_ctrl.sv
// -----------------------------------------------------------------------------
// cartpole_episode_ctrl
// Episode sequencer for the CartPole single-step datapath. Holds the 4-word
// float32 state, accepts one action at a time from the agent, issues a one-
// cycle step request to the datapath, writes the returned state back and
// presents observation/reward/flags to the agent.
//
// Ports
//   aclk, aresetn                    clock, asynchronous active-low reset
//   i_env_reset, i_init_state        start a new episode from a given state
//   i_act_valid/o_act_ready, i_act   agent action handshake
//   o_dp_signal, o_dp_action,
//   o_dp_state                       step request to the datapath
//   i_dp_next_state, i_dp_terminated,
//   i_dp_reward, i_dp_valid          datapath result (valid = nonzero)
//   o_obs_valid/i_obs_ready,
//   o_obs_state, o_reward            observation handshake to the agent
//   o_terminated, o_truncated        episode end flags
//   o_step_cnt                       steps taken this episode (saturating)
//   o_error                          sticky datapath timeout
// -----------------------------------------------------------------------------
module cartpole_episode_ctrl
    import cartpole_pkg::*;
#(
    parameter int MAX_STEPS    = 500,
    parameter int STEP_CNT_BIT = 16,
    parameter int TIMEOUT_CYC  = 64
) (
    input  logic                    aclk,
    input  logic                    aresetn,
    input  logic                    i_env_reset,
    input  logic [STATE_BIT-1:0]    i_init_state,
    input  logic                    i_act_valid,
    output logic                    o_act_ready,
    input  logic [DATA_BIT-1:0]     i_act,
    output logic                    o_dp_signal,
    output logic [DATA_BIT-1:0]     o_dp_action,
    output logic [STATE_BIT-1:0]    o_dp_state,
    input  logic [STATE_BIT-1:0]    i_dp_next_state,
    input  logic [DATA_BIT-1:0]     i_dp_terminated,
    input  logic [DATA_BIT-1:0]     i_dp_reward,
    input  logic [DATA_BIT-1:0]     i_dp_valid,
    output logic                    o_obs_valid,
    input  logic                    i_obs_ready,
    output logic [STATE_BIT-1:0]    o_obs_state,
    output logic [DATA_BIT-1:0]     o_reward,
    output logic                    o_terminated,
    output logic                    o_truncated,
    output logic [STEP_CNT_BIT-1:0] o_step_cnt,
    output logic                    o_error
);

    localparam logic [STEP_CNT_BIT-1:0] MAX_CNT  = STEP_CNT_BIT'(MAX_STEPS);
    localparam logic [STEP_CNT_BIT-1:0] LAST_CNT = STEP_CNT_BIT'(MAX_STEPS - 1);

    ctrl_state_e             state_q;
    ctrl_state_e             state_d;
    logic [STATE_BIT-1:0]    env_state_q;
    logic [STEP_CNT_BIT-1:0] step_cnt_q;

    logic dp_valid;
    logic dp_term;
    logic act_fire;
    logic obs_fire;
    logic timer_en;
    logic timer_expire;
    logic last_step;

    assign dp_valid  = |i_dp_valid;
    assign dp_term   = |i_dp_terminated;
    assign act_fire  = i_act_valid && o_act_ready;
    assign obs_fire  = o_obs_valid && i_obs_ready;
    assign last_step = (step_cnt_q == LAST_CNT);

    // The timer is zero during ISSUE and keeps counting through WAIT, so the
    // timeout lands TIMEOUT_CYC cycles after the step request went out.
    assign timer_en = (state_q == ST_ISSUE) || (state_q == ST_WAIT);

    cartpole_step_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_step_timer (
        .aclk     (aclk),
        .aresetn  (aresetn),
        .i_clr    (i_env_reset || !timer_en),
        .i_en     (timer_en),
        .o_expire (timer_expire)
    );

    // ------------------------------------------------------------------ FSM
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // NOTE: every combinational output gets a default before the case so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (i_env_reset) begin
            state_d = ST_READY;
        end else begin
            case (state_q)
                ST_READY:   if (act_fire) state_d = ST_ISSUE;
                ST_ISSUE:   state_d = ST_WAIT;
                ST_WAIT: begin
                    if (dp_valid)          state_d = ST_PRESENT;
                    else if (timer_expire) state_d = ST_ERR;
                end
                ST_PRESENT: begin
                    if (obs_fire) state_d = (o_terminated || o_truncated) ? ST_DONE : ST_READY;
                end
                default:    state_d = state_q;
            endcase
        end
    end

    always_comb begin
        o_act_ready = (state_q == ST_READY);
        o_dp_signal = (state_q == ST_ISSUE);
        o_obs_valid = (state_q == ST_PRESENT);
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            env_state_q  <= '0;
            step_cnt_q   <= '0;
            o_dp_action  <= '0;
            o_reward     <= FP_ZERO;
            o_terminated <= 1'b0;
            o_truncated  <= 1'b0;
            o_error      <= 1'b0;
        end else if (i_env_reset) begin
            env_state_q  <= i_init_state;
            step_cnt_q   <= '0;
            o_terminated <= 1'b0;
            o_truncated  <= 1'b0;
            o_error      <= 1'b0;
        end else begin
            if (act_fire) begin
                o_dp_action <= i_act;
            end
            // Results are only taken in WAIT, so a valid left over from a step
            // aborted by env-reset is ignored.
            if (state_q == ST_WAIT) begin
                if (dp_valid) begin
                    env_state_q  <= i_dp_next_state;
                    o_reward     <= i_dp_reward;
                    o_terminated <= dp_term;
                    o_truncated  <= last_step && !dp_term;
                    if (step_cnt_q != MAX_CNT) begin
                        step_cnt_q <= step_cnt_q + 1'b1;
                    end
                end else if (timer_expire) begin
                    o_error <= 1'b1;
                end
            end
        end
    end

    assign o_dp_state  = env_state_q;
    assign o_obs_state = env_state_q;
    assign o_step_cnt  = step_cnt_q;

endmodule

// File: tb/tb_cartpole_episode_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cartpole_episode_ctrl
// Self-checking bench: a directed/random driver pushes the expected observation
// of every step into a queue; a monitor pops and compares on each observation
// handshake. The episode model tracks state, step count and done as plain
// variables.
// -----------------------------------------------------------------------------
module tb_cartpole_episode_ctrl;
    import cartpole_pkg::*;

    localparam int SW     = STATE_BIT;
    localparam int DW     = DATA_BIT;
    localparam int TB_MAX = 3;
    localparam int TB_TO  = 64;
    localparam int SCW    = 16;

    logic            aclk = 1'b0;
    logic            aresetn = 1'b0;
    logic            i_env_reset = 1'b0;
    logic [SW-1:0]   i_init_state = '0;
    logic            i_act_valid = 1'b0;
    logic            o_act_ready;
    logic [DW-1:0]   i_act = '0;
    logic            o_dp_signal;
    logic [DW-1:0]   o_dp_action;
    logic [SW-1:0]   o_dp_state;
    logic [SW-1:0]   i_dp_next_state = '0;
    logic [DW-1:0]   i_dp_terminated = '0;
    logic [DW-1:0]   i_dp_reward = '0;
    logic [DW-1:0]   i_dp_valid = '0;
    logic            o_obs_valid;
    logic            i_obs_ready = 1'b0;
    logic [SW-1:0]   o_obs_state;
    logic [DW-1:0]   o_reward;
    logic            o_terminated;
    logic            o_truncated;
    logic [SCW-1:0]  o_step_cnt;
    logic            o_error;

    cartpole_episode_ctrl #(
        .MAX_STEPS    (TB_MAX),
        .STEP_CNT_BIT (SCW),
        .TIMEOUT_CYC  (TB_TO)
    ) dut (
        .aclk            (aclk),
        .aresetn         (aresetn),
        .i_env_reset     (i_env_reset),
        .i_init_state    (i_init_state),
        .i_act_valid     (i_act_valid),
        .o_act_ready     (o_act_ready),
        .i_act           (i_act),
        .o_dp_signal     (o_dp_signal),
        .o_dp_action     (o_dp_action),
        .o_dp_state      (o_dp_state),
        .i_dp_next_state (i_dp_next_state),
        .i_dp_terminated (i_dp_terminated),
        .i_dp_reward     (i_dp_reward),
        .i_dp_valid      (i_dp_valid),
        .o_obs_valid     (o_obs_valid),
        .i_obs_ready     (i_obs_ready),
        .o_obs_state     (o_obs_state),
        .o_reward        (o_reward),
        .o_terminated    (o_terminated),
        .o_truncated     (o_truncated),
        .o_step_cnt      (o_step_cnt),
        .o_error         (o_error)
    );

    always #5 aclk = ~aclk;

    typedef struct {
        logic [SW-1:0] st;
        logic [DW-1:0] rew;
        logic          term;
        logic          trunc;
        int            steps;
    } obs_t;

    obs_t exp_q[$];
    int   total = 0;
    int   bad   = 0;

    // Episode model
    logic [SW-1:0] m_state;
    int            m_steps;
    bit            m_done;

    task automatic check(input string name, input logic [SW-1:0] got, input logic [SW-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge aclk);
        #1;
    endtask

    function automatic logic [SW-1:0] rand_state();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic check_all_zero(input string tag);
        check({tag, "_act_ready"}, o_act_ready, 0);
        check({tag, "_dp_signal"}, o_dp_signal, 0);
        check({tag, "_dp_action"}, o_dp_action, 0);
        check({tag, "_dp_state"},  o_dp_state, 0);
        check({tag, "_obs_valid"}, o_obs_valid, 0);
        check({tag, "_obs_state"}, o_obs_state, 0);
        check({tag, "_reward"},    o_reward, 0);
        check({tag, "_term"},      o_terminated, 0);
        check({tag, "_trunc"},     o_truncated, 0);
        check({tag, "_step_cnt"},  o_step_cnt, 0);
        check({tag, "_error"},     o_error, 0);
    endtask

    task automatic env_reset(input logic [SW-1:0] init);
        i_init_state = init;
        i_env_reset  = 1'b1;
        tick();
        i_env_reset  = 1'b0;
        m_state = init;
        m_steps = 0;
        m_done  = 0;
    endtask

    // Offer an action; on return the step request has been pulsed and the
    // controller sits one cycle into WAIT.
    task automatic issue_action(input logic [DW-1:0] act);
        int n = 0;
        while (!o_act_ready && n < 20) begin
            tick();
            n++;
        end
        check("act_ready_wait", o_act_ready, 1);
        i_act       = act;
        i_act_valid = 1'b1;
        tick();
        i_act_valid = 1'b0;
        check("dp_signal_rise", o_dp_signal, 1);
        check("dp_state",       o_dp_state, m_state);
        check("dp_action",      o_dp_action, act);
        tick();
        check("dp_signal_pulse", o_dp_signal, 0);
    endtask

    // Datapath answers after 'dly' more cycles; agent holds ready low 'hold' cycles.
    task automatic complete_step(input bit term, input logic [DW-1:0] rew, input int dly, input int hold);
        obs_t          e;
        logic [SW-1:0] nxt;
        nxt = rand_state();
        repeat (dly) tick();
        i_dp_next_state = nxt;
        i_dp_reward     = rew;
        i_dp_terminated = term ? DW'($urandom_range(1, 1000)) : '0;
        i_dp_valid      = DW'(1) << $urandom_range(0, DW - 1);
        if (m_steps < TB_MAX) m_steps++;
        e.st    = nxt;
        e.rew   = rew;
        e.term  = term;
        e.trunc = (m_steps == TB_MAX) && !term;
        e.steps = m_steps;
        exp_q.push_back(e);
        m_state = nxt;
        m_done  = e.term || e.trunc;
        tick();
        i_dp_valid      = '0;
        i_dp_next_state = rand_state();
        i_dp_reward     = $urandom;
        check("obs_latency", o_obs_valid, 1);
        repeat (hold) begin
            check("present_act_ready", o_act_ready, 0);
            check("present_obs_valid", o_obs_valid, 1);
            tick();
        end
        i_obs_ready = 1'b1;
        tick();
        i_obs_ready = 1'b0;
        check("obs_valid_drop", o_obs_valid, 0);
        check("act_ready_after_obs", o_act_ready, !m_done);
    endtask

    task automatic act_blocked(input string tag);
        i_act_valid = 1'b1;
        i_act       = 32'd1;
        repeat (4) begin
            tick();
            check({tag, "_act_ready"}, o_act_ready, 0);
            check({tag, "_dp_signal"}, o_dp_signal, 0);
        end
        i_act_valid = 1'b0;
    endtask

    // ------------------------------------------------------------- monitor
    obs_t          mon_e;
    logic [SW-1:0] prev_st;
    logic [DW-1:0] prev_rew;
    bit            prev_hold = 0;

    always @(negedge aclk) begin
        if (!aresetn) begin
            prev_hold = 0;
        end else if (o_obs_valid) begin
            if (prev_hold) begin
                check("obs_state_stable", o_obs_state, prev_st);
                check("reward_stable",    o_reward, prev_rew);
            end
            if (i_obs_ready) begin
                check("obs_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    mon_e = exp_q.pop_front();
                    check("obs_state", o_obs_state, mon_e.st);
                    check("obs_reward", o_reward, mon_e.rew);
                    check("obs_term", o_terminated, mon_e.term);
                    check("obs_trunc", o_truncated, mon_e.trunc);
                    check("obs_steps", o_step_cnt, SW'(mon_e.steps));
                end
                prev_hold = 0;
            end else begin
                prev_hold = 1;
                prev_st   = o_obs_state;
                prev_rew  = o_reward;
            end
        end else begin
            prev_hold = 0;
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // -------------------------------------------------------------- driver
    initial begin
        logic [SW-1:0] init_a;
        logic [SW-1:0] init_b;
        int            n;
        int            guard;

        init_a = {32'h3F5F1AFC, 32'h3E53E72E, 32'hBE7002B9, 32'hBDDA4B6F};

        // Reset state
        repeat (2) tick();
        check_all_zero("rst");
        aresetn = 1'b1;
        tick();
        check("idle_act_ready", o_act_ready, 0);

        // Basic step from the reference init vector
        env_reset(init_a);
        check("init_state", o_obs_state, init_a);
        check("init_act_ready", o_act_ready, 1);
        issue_action(32'd1);
        complete_step(1'b0, FP_ONE, 5, 0);

        // Backpressure on the observation
        issue_action(32'd0);
        complete_step(1'b0, $urandom, 3, 5);

        // Terminated on the limit step: terminated wins, truncated stays 0
        issue_action(32'd1);
        complete_step(1'b1, FP_ONE, 1, 0);
        check("done_term", o_terminated, 1);
        act_blocked("done");

        // Truncation at MAX_STEPS
        env_reset(rand_state());
        check("trunc_rst_term", o_terminated, 0);
        check("trunc_rst_cnt", o_step_cnt, 0);
        for (int i = 0; i < TB_MAX; i++) begin
            issue_action(32'($urandom_range(0, 1)));
            complete_step(1'b0, $urandom, $urandom_range(0, 8), $urandom_range(0, 3));
        end
        check("trunc_flag", o_truncated, 1);
        check("trunc_cnt", o_step_cnt, TB_MAX);
        act_blocked("trunc");
        env_reset(rand_state());
        check("trunc_clr_flag", o_truncated, 0);
        check("trunc_clr_cnt", o_step_cnt, 0);

        // Datapath timeout
        issue_action(32'd1);
        n = 1;
        while (!o_error && n < TB_TO + 8) begin
            tick();
            n++;
        end
        check("timeout_error", o_error, 1);
        check("timeout_cycles", n, TB_TO);
        act_blocked("err");
        check("err_sticky", o_error, 1);
        env_reset(rand_state());
        check("err_clear", o_error, 0);
        issue_action(32'd0);
        complete_step(1'b0, $urandom, 4, 1);

        // Env-reset mid-step followed by a stale datapath valid
        issue_action(32'd1);
        repeat (2) tick();
        init_b = rand_state();
        env_reset(init_b);
        i_dp_next_state = rand_state();
        i_dp_reward     = $urandom;
        i_dp_valid      = 32'h1;
        tick();
        i_dp_valid      = '0;
        repeat (3) begin
            check("stale_obs_valid", o_obs_valid, 0);
            tick();
        end
        check("stale_state", o_obs_state, init_b);
        check("stale_cnt", o_step_cnt, 0);
        check("stale_act_ready", o_act_ready, 1);
        issue_action(32'd0);
        complete_step(1'b0, $urandom, 2, 0);

        // Asynchronous reset in the middle of a step
        issue_action(32'd1);
        #2;
        aresetn = 1'b0;
        #2;
        check_all_zero("async_rst");
        exp_q.delete();
        tick();
        tick();
        aresetn = 1'b1;
        tick();
        check("post_rst_idle", o_act_ready, 0);

        // Random episodes
        for (int ep = 0; ep < 6; ep++) begin
            env_reset(rand_state());
            guard = 0;
            while (!m_done && guard < 10) begin
                issue_action(32'($urandom_range(0, 1)));
                complete_step($urandom_range(0, 3) == 0, $urandom, $urandom_range(0, 12), $urandom_range(0, 3));
                guard++;
            end
            check("ep_done_ready", o_act_ready, 0);
        end

        repeat (3) tick();
        check("queue_drained", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cartpole_episode_ctrl.md
Name: cartpole_episode_ctrl

Overview:
Episode sequencer for the CartPole single-step compute datapath. It holds the 4-word float32 state (x, x_dot, theta, theta_dot) and accepts actions from the agent over a valid/ready handshake. For each action it issues one step request to the datapath, waits for the datapath's valid, and writes the next state back. It presents observation, reward, terminated and truncated flags to the agent, counts steps, enforces the truncation limit and flags datapath timeouts.

Parameters:
DATA_BIT, 32, float32 word width for state, action and reward
MAX_STEPS, 500, step count at which an episode is truncated
STEP_CNT_BIT, 16, width of the step counter (must hold MAX_STEPS)
TIMEOUT_CYC, 64, cycles to wait for datapath valid before error

Ports:
aclk  in  1  clock
aresetn  in  1  asynchronous active-low reset
i_env_reset  in  1  pulse: load initial state, start new episode
i_init_state  in  4*DATA_BIT  initial state {theta_dot,theta,x_dot,x}, x in bits [31:0]
i_act_valid  in  1  agent action valid
o_act_ready  out  1  controller accepts action
i_act  in  DATA_BIT  action (0 = push left, 1 = push right)
o_dp_signal  out  1  datapath step request, one-cycle pulse
o_dp_action  out  DATA_BIT  action to datapath
o_dp_state  out  4*DATA_BIT  current state to datapath
i_dp_next_state  in  4*DATA_BIT  next state from datapath
i_dp_terminated  in  DATA_BIT  nonzero = terminated
i_dp_reward  in  DATA_BIT  float32 reward
i_dp_valid  in  DATA_BIT  nonzero = result valid
o_obs_valid  out  1  observation valid
i_obs_ready  in  1  agent consumes observation
o_obs_state  out  4*DATA_BIT  observation
o_reward  out  DATA_BIT  reward of last step
o_terminated  out  1  episode ended by physics
o_truncated  out  1  episode ended by step limit
o_step_cnt  out  STEP_CNT_BIT  steps taken this episode
o_error  out  1  sticky datapath timeout

Behaviour:
- Reset (aresetn=0): FSM=IDLE; all outputs 0; state regs 0; counters 0.
- FSM states: IDLE, READY, ISSUE, WAIT, PRESENT, DONE, ERR.
- i_env_reset is honoured in every state, including mid-step, and has priority over all other events. On that cycle: state<=i_init_state, step_cnt<=0, terminated/truncated/error<=0, o_obs_valid<=0. The controller then enters READY on the next cycle.
  - A datapath valid arriving after an env-reset is discarded.
- READY: o_act_ready=1. When i_act_valid&&o_act_ready, latch i_act into o_dp_action and go to ISSUE.
- ISSUE: o_dp_signal=1 for exactly one cycle; o_dp_state holds the current state. Timeout counter is cleared. Next state is WAIT.
- WAIT: o_dp_signal=0.
  - On i_dp_valid!=0: state<=i_dp_next_state; o_reward<=i_dp_reward; o_terminated<=(i_dp_terminated!=0); step_cnt<=step_cnt+1; o_truncated<=(step_cnt+1==MAX_STEPS)&&!terminated. Next state is PRESENT.
  - If the timeout counter reaches TIMEOUT_CYC-1 without valid: o_error<=1 and go to ERR.
- PRESENT: o_obs_valid=1 and o_obs_state=state, both held until i_obs_ready. Outputs must stay stable while valid && !ready.
  - On handshake: go to DONE if terminated|truncated, else READY.
  - An action may not be accepted in PRESENT (o_act_ready=0).
- DONE: o_act_ready=0; flags held; wait for i_env_reset.
- ERR: o_act_ready=0; o_error held; exit only via i_env_reset or aresetn.
- Latency: action accept to o_dp_signal is 1 cycle; datapath valid to o_obs_valid is 1 cycle.
- step_cnt saturates at MAX_STEPS and never wraps.
- o_dp_state is always driven from the state registers. The datapath samples it only when o_dp_signal=1.

Decomposition:
- Shared package cartpole_pkg holds: DATA_BIT, state-vector slice offsets (X=0, X_DOT=1, THETA=2, THETA_DOT=3), FSM state encoding, and float32 constants (FP_ONE=32'h3F800000, FP_ZERO).
- One natural sub-module: cartpole_step_timer, a loadable timeout counter with clear and expire outputs.
- The datapath itself is instantiated one level up, not inside this block.

Test Plan:
- Env-reset with init state {3F5F1AFC,3E53E72E,BE7002B9,BDDA4B6F}, then action 1, datapath model returns valid after 7 cycles with reward 3F800000 and term 0 -> o_dp_signal high exactly 1 cycle, 1 cycle after accept; o_obs_valid 1 cycle after valid; o_step_cnt=1; o_terminated=0.
- Hold i_obs_ready=0 for 5 cycles -> o_obs_state and o_reward stable, o_act_ready=0, o_obs_valid stays high; on ready go to READY.
- Datapath returns i_dp_terminated=1 -> o_terminated=1; after obs handshake FSM is in DONE; a further i_act_valid is not accepted.
- MAX_STEPS=3 with the model never terminating -> after step 3 o_truncated=1, o_step_cnt=3, DONE; i_env_reset clears both to 0.
- Model never asserts valid -> o_error=1 exactly TIMEOUT_CYC cycles after o_dp_signal; i_env_reset clears it and a new step succeeds.
- i_env_reset during WAIT, then the stale valid arrives -> state equals the init vector, step_cnt=0, no o_obs_valid. Also: aresetn low mid-episode -> all outputs 0 immediately, without waiting for a clock edge.
